// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
// multicycle_mem_responder: single-outstanding memory responder, fixed latency
// Revision: 1.0
// ============================================================================
module multicycle_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int         c_IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WAIT     = 2'd1;
  localparam logic [1:0] c_RESP     = 2'd2;
  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-3:0]  w_index;
  logic [c_IDX_W-1:0] w_mem_idx;
  logic               w_out_of_range;
  logic               w_fault;
  logic               w_do_access;

  assign w_index   = r_addr[ADDR_W-1:2];
  assign w_mem_idx = w_index[c_IDX_W-1:0];

  // DEPTH is a power of two, so index >= DEPTH is exactly "any bit above the array index set".
  generate
    if (ADDR_W - 2 > c_IDX_W) begin : g_range_chk
      assign w_out_of_range = |w_index[ADDR_W-3:c_IDX_W];
    end else begin : g_no_range_chk
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_fault     = (r_addr[1:0] != 2'b00) || w_out_of_range;
  assign w_do_access = (r_state == c_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_din      <= 32'd0;
      dout       <= 32'd0;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (mem_read ^ mem_write) begin
            r_is_write <= mem_write;
            r_addr     <= addr;
            r_din      <= din;
            r_cnt      <= c_CNT_LOAD;
            r_state    <= c_WAIT;
            busy       <= 1'b1;
          end else if (mem_read && mem_write) begin
            err <= 1'b1;
          end
        end
        c_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= c_RESP;
            mem_ready <= 1'b1;
            err       <= w_fault;
            if (!r_is_write && !w_fault) begin
              dout <= r_mem[w_mem_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Array is deliberately not reset; a reset on the access edge discards the write.
  always_ff @(posedge clk) begin
    if (!reset && w_do_access && r_is_write && !w_fault) begin
      r_mem[w_mem_idx] <= r_din;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_multicycle_mem_responder: directed + random checks against a word-array model
// Revision: 1.0
// ============================================================================
module tb_multicycle_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd [3];
  logic        wr [3];
  logic [31:0] ad [3];
  logic [31:0] di [3];
  logic [31:0] dq [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        er [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mm [3][256];
  bit          wrt [3][256];
  logic [31:0] exp_dout [3];

  always #5 clk = ~clk;

  multicycle_mem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]), .din(di[0]),
    .dout(dq[0]), .mem_ready(rdy[0]), .busy(bsy[0]), .err(er[0]));
  multicycle_mem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]), .din(di[1]),
    .dout(dq[1]), .mem_ready(rdy[1]), .busy(bsy[1]), .err(er[1]));
  multicycle_mem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(15)) u2 (
    .clk(clk), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]), .addr(ad[2]), .din(di[2]),
    .dout(dq[2]), .mem_ready(rdy[2]), .busy(bsy[2]), .err(er[2]));

  function automatic int lat(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete transaction: request sampled at the next edge, then dropped.
  task automatic access(input int k, input bit is_wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    int bcnt;
    bit saw_err;
    bit fault;
    int idx;
    fault = (a[1:0] != 2'b00) || ((a >> 2) >= 256);
    rd[k] = !is_wr;
    wr[k] = is_wr;
    ad[k] = a;
    di[k] = d;
    step();
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    n = 0;
    bcnt = 0;
    saw_err = 0;
    while (rdy[k] !== 1'b1 && n < 40) begin
      if (bsy[k] === 1'b1) bcnt++;
      if (er[k] !== 1'b0) saw_err = 1;
      step();
      n++;
    end
    if (bsy[k] === 1'b1) bcnt++;
    chk($sformatf("latency_u%0d_a%h", k, a), n, lat(k));
    chk($sformatf("busy_len_u%0d_a%h", k, a), bcnt, lat(k) + 1);
    chk($sformatf("err_early_u%0d_a%h", k, a), saw_err, 0);
    chk($sformatf("err_at_ready_u%0d_a%h", k, a), er[k], fault);
    if (!fault) begin
      idx = int'(a >> 2);
      if (is_wr) begin
        mm[k][idx] = d;
        wrt[k][idx] = 1;
      end else begin
        exp_dout[k] = mm[k][idx];
      end
    end
    chk($sformatf("dout_u%0d_a%h", k, a), dq[k], exp_dout[k]);
    step();
    chk($sformatf("idle_after_u%0d_a%h", k, a), {bsy[k], rdy[k], er[k]}, 3'b000);
  endtask

  initial begin
    int n;
    int t_acc;
    int t [3];
    bit saw;
    logic [31:0] a;
    logic [31:0] d;
    int idx;
    int r;

    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = 32'd0; di[k] = 32'd0; exp_dout[k] = 32'd0;
      for (int i = 0; i < 256; i++) wrt[k][i] = 0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ready_u%0d", k), rdy[k], 1'b0);
      chk($sformatf("reset_busy_u%0d", k), bsy[k], 1'b0);
      chk($sformatf("reset_err_u%0d", k), er[k], 1'b0);
      chk($sformatf("reset_dout_u%0d", k), dq[k], 32'd0);
    end
    reset = 1'b0;
    step();

    // Basic write then read
    access(0, 1, 32'h10, 32'hDEADBEEF);
    access(0, 0, 32'h10, 32'h0);

    // Misaligned and out-of-range faults keep dout
    access(0, 0, 32'h13, 32'h0);
    access(0, 0, 32'h400, 32'h0);

    // Simultaneous read and write
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h10;
    step();
    chk("both_err", er[0], 1'b1);
    chk("both_busy", bsy[0], 1'b0);
    chk("both_ready", rdy[0], 1'b0);
    rd[0] = 1'b0; wr[0] = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (er[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0) saw = 1;
    end
    chk("both_quiet_after", saw, 0);

    // Reset aborts a pending write
    access(2, 1, 32'h20, 32'h11111111);
    wr[2] = 1'b1; ad[2] = 32'h20; di[2] = 32'h12345678;
    step();
    wr[2] = 1'b0;
    step();
    step();
    chk("abort_busy_in_wait", bsy[2], 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) exp_dout[k] = 32'd0;
    chk("abort_ready", rdy[2], 1'b0);
    chk("abort_busy", bsy[2], 1'b0);
    chk("abort_err", er[2], 1'b0);
    chk("abort_dout", dq[2], 32'd0);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rdy[2] !== 1'b0 || bsy[2] !== 1'b0) saw = 1;
    end
    chk("abort_no_ready", saw, 0);
    access(2, 0, 32'h20, 32'h0);

    // Held read request: re-accepted one cycle after each pulse
    rd[0] = 1'b1; ad[0] = 32'h10;
    step();
    t_acc = cyc;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (rdy[0] !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      t[p] = cyc;
      chk($sformatf("held_dout_%0d", p), dq[0], 32'hDEADBEEF);
      if (p < 2) step();
    end
    rd[0] = 1'b0;
    exp_dout[0] = 32'hDEADBEEF;
    chk("held_first", t[0] - t_acc, 2);
    chk("held_gap1", t[1] - t[0], 4);
    chk("held_gap2", t[2] - t[1], 4);
    step();
    chk("held_released_busy", bsy[0], 1'b0);
    step();
    chk("held_no_reaccept", bsy[0], 1'b0);

    // Latency extremes at the top word of a 256-word array
    access(1, 1, 32'h3FC, $urandom);
    access(1, 0, 32'h3FC, 32'h0);
    access(2, 1, 32'h3FC, $urandom);
    access(2, 0, 32'h3FC, 32'h0);

    // Randomized traffic on the LATENCY=2 instance
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      d = $urandom;
      if (r == 0) begin
        a = (idx << 2) + $urandom_range(1, 3);
        access(0, 1'($urandom_range(0, 1)), a, d);
      end else if (r == 1) begin
        a = $urandom_range(256, 4095) << 2;
        access(0, 1'($urandom_range(0, 1)), a, d);
      end else begin
        a = idx << 2;
        access(0, ($urandom_range(0, 1) == 1) || !wrt[0][idx], a, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
